load_store_unit: RTL and testbench
==================================

# load_store_unit

- Data-memory access unit between the execute stage and a synchronous data RAM.
- Converts load/store requests (byte/half/word, signed or unsigned) into a req/ack bus transaction with byte enables.
- Stalls the pipeline until the access completes.
- Returns the aligned, extended load word on `DataOut`, which feeds the memory input of the register-file write-back selector driven by `MemOrReg`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: ack watchdog limit in cycles; used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request; wins over `MemRead` if both are set.
- `Addr` input 32: byte address, taken from `ALUResult`.
- `WriteData` input 32: store data; value in the low bits.
- `Size` input 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `Unsigned` input 1: zero-extend loads; otherwise sign-extend.
- `DataOut` output 32: registered load result.
- `Stall` output 1: hold the pipeline.
- `MisalignErr` output 1: one-cycle pulse on a misaligned request.
- `BusErr` output 1: one-cycle pulse on a watchdog timeout.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: word address, with `Addr[1:0]` forced to 00.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_be` output 4: byte enables; bit n covers byte n (little-endian).
- `mem_rdata` input 32: read data; valid in the cycle `mem_ack`=1.
- `mem_ack` input 1: transaction complete.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - When `MemRead|MemWrite` is set and the access is aligned: latch address, we, be, wdata, size and unsigned; go to REQ.
  - Alignment rule: half needs `Addr[0]`=0; word needs `Addr[1:0]`=00.
  - Misaligned request: no bus cycle; `MisalignErr`=1 for that cycle; stay in IDLE.
- **REQ**
  - `mem_req`=1, with all bus outputs stable from registers.
  - On `mem_ack`, for a load, register the formatted read data into `DataOut`; go to DONE.
  - Stores leave `DataOut` unchanged.
- **DONE**
  - Lasts one cycle; return to IDLE.
  - Request inputs are ignored in this cycle, because they still belong to the finished instruction.
- Store lane replication:
  - byte: `{4{WriteData[7:0]}}`, `mem_be` = 0001 shifted left by `Addr[1:0]`.
  - half: `{2{WriteData[15:0]}}`, `mem_be` = 0011 (`Addr[1]`=0) or 1100 (`Addr[1]`=1).
  - word: data passes unchanged, `mem_be`=1111.
- Load formatting:
  - Select the byte lane `Addr[1:0]` or half lane `Addr[1]` from `mem_rdata`.
  - Extend to 32 bits: sign-extend unless `Unsigned`.
  - Word loads pass through unchanged.
- `mem_be`=0000 and `mem_we`=0 whenever `mem_req`=0.

## Timing
- Reset values: `DataOut`=0, `Stall`=0, `MisalignErr`=0, `BusErr`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0. State is IDLE.
- `Stall` is combinational:
  - 1 in IDLE when an aligned request is present.
  - 1 throughout REQ.
  - 0 in DONE.
- Minimum latency is 3 cycles (IDLE, REQ with same-cycle ack, DONE). Each extra ack wait adds one cycle.
- `DataOut` is valid from the first cycle of DONE and holds until the next load completes.
- `mem_ack` outside REQ is ignored.
- Reset asserted mid-REQ: `mem_req` drops immediately (asynchronous), FSM goes to IDLE, and any in-flight result is discarded.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in REQ.
  - If `TIMEOUT_CYCLES` cycles pass without `mem_ack`: drop `mem_req`, pulse `BusErr` for one cycle, load `DataOut`=0, go to DONE.
- `LSU_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `BusErr` is tied to 0 and no counter is present.

## Test plan
- **Signed byte load:** LB signed, `Addr`=0x1003, `mem_rdata`=0x80_12_34_56, ack on the first REQ cycle.
  - Bus: `mem_addr`=0x1000, `mem_be`=1000 held during REQ.
  - Result: `DataOut`=0xFFFFFF80 in DONE; `Stall` high for exactly 2 cycles.
- **Unsigned half load:** LHU, `Addr`=0x2002, `mem_rdata`=0xBEEF_0000, ack delayed 3 cycles.
  - Result: `DataOut`=0x0000BEEF; `Stall` high for 5 cycles.
- **Byte store:** SB, `Addr`=0x0001, `WriteData`=0x000000A5.
  - Bus: `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xA5A5A5A5.
  - `DataOut` unchanged.
- **Misaligned word load:** LW, `Addr`=0x0006.
  - `MisalignErr` pulses for 1 cycle; `mem_req` never asserts; `Stall`=0.
- **Reset mid-transaction:** assert `rst` during REQ while `mem_ack`=0.
  - `mem_req`=0 in the same cycle; `DataOut`=0; FSM in IDLE after release.
- **Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** `mem_ack` never asserts.
  - `BusErr` pulses after 4 REQ cycles; `DataOut`=0.
  - Pipeline released one cycle later.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into a req/ack bus cycle and formats load data.
// Optional ack watchdog is compiled in when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] DataOut,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] data_out_q, data_out_d;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic        we_q, unsigned_q;
  logic        bus_err_q, bus_err_d;

  logic        req_any, misaligned, accept, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_fmt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign req_any = MemRead | MemWrite;

  always_comb begin
    case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Addr[0];
      default: misaligned = |Addr[1:0];
    endcase
  end

  assign accept = (state_q == StIdle) && req_any && !misaligned;

  always_comb begin
    case (Size)
      2'b00: begin
        wdata_new = {4{WriteData[7:0]}};
        be_new    = 4'b0001 << Addr[1:0];
      end
      2'b01: begin
        wdata_new = {2{WriteData[15:0]}};
        be_new    = Addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_new = WriteData;
        be_new    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_fmt = {{24{~unsigned_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_fmt = {{16{~unsigned_q & rd_half[15]}}, rd_half};
      default: load_fmt = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q is 0 in the first REQ cycle, so the watchdog fires in REQ cycle TIMEOUT_CYCLES.
  assign cnt_d   = (state_q == StReq) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == StReq) && !mem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    bus_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StReq;
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) data_out_d = load_fmt;
        end else if (timeout) begin
          state_d    = StDone;
          bus_err_d  = 1'b1;
          data_out_d = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      data_out_q <= '0;
      bus_err_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      bus_err_q  <= bus_err_d;
      if (accept) begin
        addr_q     <= Addr;
        wdata_q    <= wdata_new;
        be_q       <= be_new;
        size_q     <= Size;
        we_q       <= MemWrite;
        unsigned_q <= Unsigned;
      end
    end
  end

  assign mem_req     = (state_q == StReq);
  assign mem_we      = mem_req & we_q;
  assign mem_be      = mem_req ? be_q : 4'b0000;
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_wdata   = wdata_q;
  assign DataOut     = data_out_q;
  assign BusErr      = bus_err_q;
  assign Stall       = accept | (state_q == StReq);
  assign MisalignErr = (state_q == StIdle) && req_any && misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random requests against a byte-addressed memory model,
// plus directed signed/unsigned loads, stores, misalignment, reset abort and (optional) timeout.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned TimeoutCycles = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Unsigned;
  logic [31:0] Addr, WriteData;
  logic [1:0]  Size;
  logic [31:0] DataOut;
  logic        Stall, MisalignErr, BusErr;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .Size       (Size),
    .Unsigned   (Unsigned),
    .DataOut    (DataOut),
    .Stall      (Stall),
    .MisalignErr(MisalignErr),
    .BusErr     (BusErr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
    logic        bus_err;
  } res_t;

  bus_t        bus_q[$];
  res_t        res_q[$];
  logic [31:0] mis_q[$];
  int          delay_q[$];

  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] last_out;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] wa);
    if (bus_mem.exists(wa)) return bus_mem[wa];
    return init_word(wa);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic preload(input logic [31:0] wa, input logic [31:0] val);
    ref_mem[wa] = val;
    bus_mem[wa] = val;
  endtask

  // Computes the expected bus cycle and result, then drives the request until Stall releases.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns, input int dly);
    int          nbytes, sh;
    logic [31:0] wa, w, v, mask;
    logic        timed_out;
    bus_t        b;
    res_t        r;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh     = int'(a[1:0]);
    wa     = a & ~32'h3;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
`ifdef LSU_TIMEOUT_EN
    timed_out = (dly >= int'(TimeoutCycles));
`else
    timed_out = 1'b0;
`endif
    if (rd || wr) begin
      if ((sh % nbytes) != 0) begin
        mis_q.push_back(a);
      end else begin
        b.addr  = wa;
        b.we    = wr;
        b.be    = 4'(((1 << nbytes) - 1) << sh);
        b.wdata = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        bus_q.push_back(b);
        delay_q.push_back(dly);
        r.bus_err = 1'b0;
        r.stall   = 2 + dly;
        if (timed_out) begin
          last_out  = 32'h0;
          r.bus_err = 1'b1;
          r.stall   = 1 + int'(TimeoutCycles);
        end else if (wr) begin
          w = ref_rd(wa);
          for (int i = 0; i < nbytes; i++) w[8 * (sh + i) +: 8] = wd[8 * i +: 8];
          ref_mem[wa] = w;
        end else begin
          v = (ref_rd(wa) >> (8 * sh)) & mask;
          if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
          last_out = v;
        end
        r.data = last_out;
        res_q.push_back(r);
      end
    end
    MemRead   = rd;
    MemWrite  = wr;
    Addr      = a;
    WriteData = wd;
    Size      = sz;
    Unsigned  = uns;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!Stall) break;
      if (n > 2000) begin
        errors++;
        $display("FAIL stall_release: Stall still 1 after %0d cycles, expected release", n);
        finish_now();
      end
    end
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Memory responder: serves requests after the queued ack delay, random noise elsewhere.
  initial begin
    int          cnt;
    bit          busy;
    logic [31:0] w;
    busy      = 1'b0;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
        end
        if (cnt == 0) begin
          mem_ack   = 1'b1;
          w         = bus_rd(mem_addr);
          mem_rdata = w;
          if (mem_we) begin
            for (int i = 0; i < 4; i++) if (mem_be[i]) w[8 * i +: 8] = mem_wdata[8 * i +: 8];
            bus_mem[mem_addr] = w;
          end
        end else begin
          cnt--;
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        busy      = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks bus cycles, completion results, stall length and error pulses.
  initial begin
    bus_t cur;
    res_t r;
    logic prev_req;
    int   stall_run;
    cur       = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0};
    prev_req  = 1'b0;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req  = 1'b0;
        stall_run = 0;
      end else begin
        if (Stall) stall_run++;
        if (mem_req) begin
          if (!prev_req) begin
            if (bus_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req: got request to %h, expected none", mem_addr);
            end else begin
              cur = bus_q.pop_front();
            end
          end
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", 32'(mem_we), 32'(cur.we));
          check("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end else begin
          check("idle_be_we", {27'h0, mem_we, mem_be}, 32'h0);
          if (prev_req) begin
            if (res_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got completion, expected none");
            end else begin
              r = res_q.pop_front();
              check("DataOut", DataOut, r.data);
              check("stall_cycles", 32'(stall_run), 32'(r.stall));
              check("BusErr", 32'(BusErr), 32'(r.bus_err));
            end
            stall_run = 0;
          end else begin
            check("BusErr_quiet", 32'(BusErr), 32'h0);
          end
        end
        if (MisalignErr) begin
          if (mis_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_misalign: got MisalignErr at Addr %h, expected none", Addr);
          end else begin
            void'(mis_q.pop_front());
            check("misalign_quiet", {30'h0, mem_req, Stall}, 32'h0);
          end
        end
        prev_req = mem_req;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Addr      = '0;
    WriteData = '0;
    Size      = '0;
    Unsigned  = 1'b0;
    last_out  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_DataOut", DataOut, 32'h0);
    check("rst_flags", {28'h0, Stall, MisalignErr, BusErr, mem_req}, 32'h0);
    check("rst_mem_we_be", {27'h0, mem_we, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    preload(32'h1000, 32'h8012_3456);
    preload(32'h2000, 32'hBEEF_0000);

    issue(1'b1, 1'b0, 32'h1003, 32'h0, 2'b00, 1'b0, 0);
    check("lb_signed", DataOut, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b1, 3);
    check("lhu", DataOut, 32'h0000_BEEF);
    issue(1'b0, 1'b1, 32'h0001, 32'h0000_00A5, 2'b00, 1'b0, 0);
    check("sb_keeps_DataOut", DataOut, 32'h0000_BEEF);
    issue(1'b1, 1'b0, 32'h0006, 32'h0, 2'b10, 1'b0, 0);
    check("misaligned_keeps_DataOut", DataOut, 32'h0000_BEEF);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        issue(1'b0, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 0);
      end
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while a load waits for its ack: the result must be dropped.
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 0);
    check("lw_before_reset", DataOut, 32'h8012_3456);
    bus_q.push_back('{addr: 32'h3000, we: 1'b0, be: 4'hF, wdata: 32'h0});
    delay_q.push_back(50);
    MemRead = 1'b1;
    Size    = 2'b10;
    Addr    = 32'h3000;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (mem_req) break;
      if (n > 10) begin
        errors++;
        $display("FAIL reset_req_wait: mem_req 0, expected 1");
        finish_now();
      end
    end
    @(negedge clk);
    #2;
    rst     = 1'b1;
    MemRead = 1'b0;
    #1;
    check("rst_async_req", {30'h0, mem_req, Stall}, 32'h0);
    check("rst_async_be", 32'(mem_be), 32'h0);
    check("rst_async_DataOut", DataOut, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_out = 32'h0;
    delay_q.delete();
    check("rst_bus_q_empty", 32'(bus_q.size()), 32'h0);
    issue(1'b1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b0, 1);
    check("lh_after_reset", DataOut, 32'hFFFF_BEEF);

`ifdef LSU_TIMEOUT_EN
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 1000);
    check("timeout_DataOut", DataOut, 32'h0);
    delay_q.delete();
`endif

    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    check("res_q_drained", 32'(res_q.size()), 32'h0);
    check("mis_q_drained", 32'(mis_q.size()), 32'h0);
    check("final_DataOut", DataOut, last_out);
    finish_now();
  end

endmodule
